fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if_id_reg.sv | 65 ++++++
 rtl/fetch_stage.sv | 175 +++++++++++++++++
 tb/tb_fetch_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: fetch FSM state
// encoding, default reset PC / bubble instruction, and PC arithmetic.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Sequential next PC; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > keep > load > bubble.
// A bubble clears valid and loads NOP_INST but leaves the PC fields alone.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        keep_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    logic [31:0] pc_q, pc_d, pc4_q, pc4_d, inst_q, inst_d;
    logic        valid_q, valid_d;

    // Next IF/ID contents from the keep/flush/load priority chain
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        if (flush_i) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (keep_i) begin
            inst_d  = inst_q;
            valid_d = valid_q;
        end else if (load_i) begin
            pc_d    = pc_i;
            pc4_d   = pc_plus4(pc_i);
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    // IF/ID storage with synchronous reset to an empty bubble at RESET_PC
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            pc4_q   <= pc_plus4(RESET_PC);
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight,
// and feeds the IF/ID register. Responses made stale by a redirect are
// dropped. Optional FETCH_MISALIGN_CHECK_EN halts on a misaligned redirect
// target; otherwise the target's low two bits are forced to zero.
//
// Handshake: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both 1; imem_req_valid/imem_addr come only from
// registers and stay stable until accepted. The memory answers with a single
// imem_resp_valid pulse no earlier than the cycle after acceptance; there is
// no response backpressure.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep_PC,
    input  logic        keep_IF_ID,
    input  logic        flush_IF_ID,
    input  logic        npc_op,
    input  logic [31:0] npc_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] pc_ID,
    output logic [31:0] pc4_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_inst_q, hold_inst_d;
    logic         drop_q, drop_d;
    logic         deliver_ok;
    logic         load_if_id;
    logic [31:0]  load_inst;
    logic [31:0]  redirect_pc;
    logic         redirect_bad;

    assign deliver_ok = ~keep_PC & ~keep_IF_ID & ~flush_IF_ID & ~npc_op;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign redirect_pc  = npc_target;
    assign redirect_bad = |npc_target[1:0];
    assign misalign_d   = misalign_q | ((state_q != S_HALT) & npc_op & redirect_bad);

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign misalign_err = misalign_q;
`else
    assign redirect_pc  = npc_target & ~32'h3;
    assign redirect_bad = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // State register: FSM state, PC, stale-response flag, held instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            hold_inst_q <= NOP_INST;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // Next-state logic; a redirect overrides everything except S_HALT
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        hold_inst_d = hold_inst_q;
        load_if_id  = 1'b0;
        load_inst   = hold_inst_q;
        if ((state_q != S_HALT) && npc_op) begin
            pc_d = redirect_pc;
            if (redirect_bad) begin
                state_d = S_HALT;
                drop_d  = 1'b0;
            end else begin
                case (state_q)
                    S_REQ: begin
                        // Request accepted this cycle already targets the old path
                        if (imem_req_ready) begin
                            state_d = S_WAIT;
                            drop_d  = 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_resp_valid) begin
                            state_d = S_REQ;
                            drop_d  = 1'b0;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                    S_HOLD:  state_d = S_REQ;
                    default: ;
                endcase
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    drop_d = 1'b0;
                    if (imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (deliver_ok) begin
                            load_if_id = 1'b1;
                            load_inst  = imem_resp_data;
                            pc_d       = pc_plus4(pc_q);
                            state_d    = S_REQ;
                        end else begin
                            hold_inst_d = imem_resp_data;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (deliver_ok) begin
                        load_if_id = 1'b1;
                        load_inst  = hold_inst_q;
                        pc_d       = pc_plus4(pc_q);
                        state_d    = S_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: request interface driven purely from registered state
    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_addr      = pc_q;
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush_IF_ID | npc_op),
        .keep_i  (keep_IF_ID),
        .load_i  (load_if_id),
        .pc_i    (pc_q),
        .inst_i  (load_inst),
        .pc_o    (pc_ID),
        .pc4_o   (pc4_ID),
        .inst_o  (inst_ID),
        .valid_o (valid_ID)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random hazard
// traffic, checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        keep_PC, keep_IF_ID, flush_IF_ID, npc_op;
    logic [31:0] npc_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] pc_ID, pc4_ID, inst_ID;
    logic        valid_ID, misalign_err;

    int errors = 0;
    int checks = 0;

    // model of the stage at transaction level
    logic [31:0] m_pc, m_held;
    bit          m_out, m_stale, m_held_v, m_halt, m_err;
    logic [31:0] e_pc, e_pc4, e_inst;
    bit          e_valid;
    // memory model
    bit          mem_busy;
    logic [31:0] mem_addr;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .keep_PC(keep_PC), .keep_IF_ID(keep_IF_ID), .flush_IF_ID(flush_IF_ID),
        .npc_op(npc_op), .npc_target(npc_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .pc_ID(pc_ID), .pc4_ID(pc4_ID), .inst_ID(inst_ID), .valid_ID(valid_ID),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        keep_PC = 0; keep_IF_ID = 0; flush_IF_ID = 0; npc_op = 0;
        npc_target = 0; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = 0; m_held = 0; m_out = 0; m_stale = 0; m_held_v = 0; m_halt = 0; m_err = 0;
        e_pc = 0; e_pc4 = 32'd4; e_inst = NOP; e_valid = 0;
        mem_busy = 0; mem_addr = 0;
    endtask

    task automatic step(input bit kpc, input bit kif, input bit fl, input bit np,
                        input logic [31:0] tgt, input bit rdy, input bit rv);
        bit exp_rv, fired, resp, permit, delivered;
        logic [31:0] d_pc, d_inst;
        keep_PC = kpc; keep_IF_ID = kif; flush_IF_ID = fl; npc_op = np;
        npc_target = tgt; imem_req_ready = rdy;
        imem_resp_valid = rv && mem_busy;
        imem_resp_data  = mem_busy ? word(mem_addr) : $urandom;

        exp_rv = !m_halt && !m_out && !m_held_v;
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        if (exp_rv) chk("imem_addr", imem_addr, m_pc);

        fired = exp_rv && rdy;
        resp = imem_resp_valid && m_out;
        permit = !kpc && !kif && !fl && !np;
        delivered = 0;
        d_pc = m_pc; d_inst = NOP;
        if (!m_halt) begin
            if (np) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if (tgt[1:0] != 2'b00) begin
                    m_halt = 1; m_err = 1; m_pc = tgt;
                    m_out = 0; m_stale = 0; m_held_v = 0;
                end else
`endif
                begin
                    m_pc = {tgt[31:2], 2'b00};
                    m_held_v = 0;
                    if (m_out) begin
                        if (resp) begin m_out = 0; m_stale = 0; end
                        else m_stale = 1;
                    end else if (fired) begin
                        m_out = 1; m_stale = 1;
                    end
                end
            end else if (fired) begin
                m_out = 1; m_stale = 0;
            end else if (m_out && resp) begin
                m_out = 0;
                if (m_stale) m_stale = 0;
                else if (permit) begin
                    delivered = 1; d_inst = word(m_pc); m_pc = m_pc + 32'd4;
                end else begin
                    m_held_v = 1; m_held = word(m_pc);
                end
            end else if (m_held_v && permit) begin
                delivered = 1; d_inst = m_held; m_held_v = 0; m_pc = m_pc + 32'd4;
            end
        end
        if (fl || np) begin
            e_inst = NOP; e_valid = 0;
        end else if (kif) begin
            // unchanged
        end else if (delivered) begin
            e_pc = d_pc; e_pc4 = d_pc + 32'd4; e_inst = d_inst; e_valid = 1;
        end else begin
            e_inst = NOP; e_valid = 0;
        end

        if (imem_resp_valid) mem_busy = 0;
        if (imem_req_valid && imem_req_ready) begin mem_busy = 1; mem_addr = imem_addr; end

        @(posedge clk); #1;
        chk("valid_ID", {31'd0, valid_ID}, {31'd0, e_valid});
        chk("inst_ID", inst_ID, e_inst);
        chk("pc_ID", pc_ID, e_pc);
        chk("pc4_ID", pc4_ID, e_pc4);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    endtask

    initial begin
        logic [31:0] t;
        // reset state
        do_reset();
        chk("rst_valid", {31'd0, valid_ID}, 32'd0);
        chk("rst_inst", inst_ID, NOP);
        chk("rst_pc_ID", pc_ID, 32'h0);
        chk("rst_pc4_ID", pc4_ID, 32'h4);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rst_addr", imem_addr, 32'h0);

        // zero-wait streaming
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 1, 1);
            if (i % 2 == 1) begin
                chk("stream_pc", pc_ID, 32'(i / 2) * 32'd4);
                chk("stream_valid1", {31'd0, valid_ID}, 32'd1);
            end else begin
                chk("stream_valid0", {31'd0, valid_ID}, 32'd0);
            end
        end

        // load-use stall
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0, 1, 1);
        chk("stall_keep_pc", pc_ID, 32'h4);
        step(1, 1, 0, 0, 0, 1, 1);
        chk("stall_keep_pc2", pc_ID, 32'h4);
        chk("stall_keep_valid", {31'd0, valid_ID}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("stall_release_pc", pc_ID, 32'h8);
        chk("stall_release_inst", inst_ID, word(32'h8));

        // redirect while waiting
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 32'h100, 1, 0);
        chk("redir_wait_bubble", {31'd0, valid_ID}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("redir_wait_stale", {31'd0, valid_ID}, 32'd0);
        chk("redir_wait_addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("redir_wait_pc", pc_ID, 32'h100);

        // redirect coinciding with the response
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 32'h200, 1, 1);
        chk("redir_same_valid", {31'd0, valid_ID}, 32'd0);
        chk("redir_same_req", {31'd0, imem_req_valid}, 32'd1);
        chk("redir_same_addr", imem_addr, 32'h200);

        // slow memory
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("slow_addr", imem_addr, 32'h200);
            chk("slow_valid", {31'd0, valid_ID}, 32'd0);
        end

        // PC wrap
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("wrap_pc", pc_ID, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4_ID, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        // misaligned redirect halts fetch until reset
        step(0, 0, 0, 1, 32'h102, 1, 0);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 1);
            chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        do_reset();
        chk("mis_cleared", {31'd0, misalign_err}, 32'd0);
`else
        // misaligned redirect target is forced to word alignment
        step(0, 0, 0, 1, 32'h302, 0, 0);
        chk("align_addr", imem_addr, 32'h300);
        chk("align_err", {31'd0, misalign_err}, 32'd0);
`endif

        // random hazard traffic, with one reset mid-transaction
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) do_reset();
            t = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            t[1:0] = 2'b00;
`endif
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                 t, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
